// File: rtl/adder_pkg.sv
// adder_pkg: op encoding, flag-vector indices and default geometry for the pipelined adder
package adder_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam int FLG_S = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_C = 2;
  localparam int FLG_P = 3;
  localparam int FLG_V = 4;
  localparam int NFLG = 5;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;
endpackage

// File: rtl/cla_slice.sv
// cla_slice: CHUNK-bit carry-lookahead adder slice, every carry derived directly from p/g and ci
module cla_slice
  import adder_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);
  logic [CHUNK-1:0] p, g;
  logic [CHUNK:0] c;
  assign p = a ^ b;
  assign g = a & b;
  always_comb begin
    c = '0;
    for (int i = 0; i <= CHUNK; i++) begin
      c[i] = ci;
      for (int j = 0; j < i; j++) c[i] = g[j] | (p[j] & c[i]);
    end
  end
  assign s = p ^ c[CHUNK-1:0];
  assign co = c[CHUNK];
endmodule

// File: rtl/pipelined_adder_flags.sv
// pipelined_adder_flags: add/sub resolving one CHUNK per stage with registered carries, plus S/Z/C/P/V flags.
// Define PIPE_ADDER_SAT_EN to saturate Z on signed overflow.
module pipelined_adder_flags
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic             Sign,
  output logic             Zero,
  output logic             Carry,
  output logic             Parity,
  output logic             Overflow
);
  localparam int NSTG = WIDTH / CHUNK;
  logic advance;
  logic [WIDTH-1:0] yb;
  logic [WIDTH-1:0] z_q [NSTG];
  logic [WIDTH-1:0] a_q [NSTG];
  logic [WIDTH-1:0] b_q [NSTG];
  logic v_q [NSTG];
  logic c_q [NSTG];
  logic am_q [NSTG];
  logic bm_q [NSTG];
  assign advance = ~out_valid | out_ready;
  assign in_ready = advance;
  assign yb = (sub == OP_SUB) ? ~Y : Y;
  genvar k;
  for (k = 0; k < NSTG; k++) begin : g_stg
    logic [WIDTH-1:0] a_in, b_in, z_in;
    logic c_in, v_in, am_in, bm_in, co;
    logic [CHUNK-1:0] s;
    if (k == 0) begin : g_first
      assign a_in = X;
      assign b_in = yb;
      assign z_in = '0;
      assign c_in = (sub == OP_SUB) | cin;
      assign v_in = in_valid;
      assign am_in = X[WIDTH-1];
      assign bm_in = yb[WIDTH-1];
    end else begin : g_next
      assign a_in = a_q[k-1];
      assign b_in = b_q[k-1];
      assign z_in = z_q[k-1];
      assign c_in = c_q[k-1];
      assign v_in = v_q[k-1];
      assign am_in = am_q[k-1];
      assign bm_in = bm_q[k-1];
    end
    cla_slice #(.CHUNK(CHUNK)) u_cla (
      .a(a_in[CHUNK-1:0]),
      .b(b_in[CHUNK-1:0]),
      .ci(c_in),
      .s(s),
      .co(co)
    );
    // operands shift down one chunk per stage so each slice always reads the low bits
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        v_q[k] <= 1'b0;
        z_q[k] <= '0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        am_q[k] <= 1'b0;
        bm_q[k] <= 1'b0;
      end else if (advance) begin
        v_q[k] <= v_in;
        z_q[k] <= z_in | (WIDTH'(s) << (k * CHUNK));
        c_q[k] <= co;
        a_q[k] <= a_in >> CHUNK;
        b_q[k] <= b_in >> CHUNK;
        am_q[k] <= am_in;
        bm_q[k] <= bm_in;
      end
  end
  logic [WIDTH-1:0] zr, zf;
  logic am, bm, ovf;
  logic [NFLG-1:0] flg;
  assign zr = z_q[NSTG-1];
  assign am = am_q[NSTG-1];
  assign bm = bm_q[NSTG-1];
  assign ovf = (am & bm & ~zr[WIDTH-1]) | (~am & ~bm & zr[WIDTH-1]);
`ifdef PIPE_ADDER_SAT_EN
  // on overflow both operands share a sign, so am alone picks the saturation rail
  assign zf = ovf ? {am, {(WIDTH-1){~am}}} : zr;
`else
  assign zf = zr;
`endif
  assign flg[FLG_S] = zf[WIDTH-1];
  assign flg[FLG_Z] = ~|zf;
  assign flg[FLG_C] = c_q[NSTG-1];
  assign flg[FLG_P] = ~^zf;
  assign flg[FLG_V] = ovf;
  assign out_valid = v_q[NSTG-1];
  assign Z = zf;
  assign Sign = flg[FLG_S];
  assign Zero = flg[FLG_Z];
  assign Carry = flg[FLG_C];
  assign Parity = flg[FLG_P];
  assign Overflow = flg[FLG_V];
endmodule

// File: tb/tb_pipelined_adder_flags.sv
// tb_pipelined_adder_flags: directed vectors with a queue scoreboard and an independent output monitor
module tb_pipelined_adder_flags;
  localparam int W = 16;
  localparam int NSTG = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic sub = 1'b0;
  logic cin = 1'b0;
  logic out_ready = 1'b1;
  logic [W-1:0] X = '0;
  logic [W-1:0] Y = '0;
  logic in_ready, out_valid, Sign, Zero, Carry, Parity, Overflow;
  logic [W-1:0] Z;
  typedef struct {
    logic [W-1:0] z;
    logic [4:0] f;
    int acc;
    bit lat;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  pipelined_adder_flags #(.WIDTH(W), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .X(X), .Y(Y), .sub(sub), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .Z(Z),
    .Sign(Sign), .Zero(Zero), .Carry(Carry), .Parity(Parity), .Overflow(Overflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, act, exp);
    end
  endtask
  // flags expected as {Sign, Zero, Carry, Parity, Overflow}
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input logic c,
                      input logic [W-1:0] ez, input logic [4:0] ef, input bit lat);
    int n = 0;
    X = x; Y = y; sub = s; cin = c; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout x=%h y=%h", x, y);
    end else begin
      @(posedge clk);
      #1;
      q.push_back('{ez, ef, cyc, lat});
    end
    in_valid = 1'b0;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid && !out_ready) chk("stall_in_ready", W'(in_ready), W'(0));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_out got=%h exp=none", Z);
        end else begin
          e = q.pop_front();
          chk("z", Z, e.z);
          chk("flags", W'({Sign, Zero, Carry, Parity, Overflow}), W'(e.f));
          if (e.lat) chk("latency", W'(cyc + 1 - e.acc), W'(NSTG));
        end
      end
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_z", Z, W'(0));
    chk("rst_flags", W'({Sign, Zero, Carry, Parity, Overflow}), W'(5'b01010));
    @(posedge clk);
    #1 rst_n = 1'b1;
`ifdef PIPE_ADDER_SAT_EN
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 5'b00001, 1'b1);
`else
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 5'b10001, 1'b1);
`endif
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 5'b01110, 1'b1);
    send(16'h1234, 16'h0000, 1'b0, 1'b1, 16'h1235, 5'b00010, 1'b1);
    send(16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 5'b10000, 1'b1);
`ifdef PIPE_ADDER_SAT_EN
    send(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h8000, 5'b10101, 1'b1);
`else
    send(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 5'b00101, 1'b1);
`endif
    repeat (8) @(posedge clk);
    #1;
    fork
      begin
        send(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 5'b00010, 1'b0);
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 5'b00000, 1'b0);
        send(16'h0F0F, 16'h00F0, 1'b0, 1'b0, 16'h0FFF, 5'b00010, 1'b0);
        send(16'h0010, 16'h0010, 1'b1, 1'b0, 16'h0000, 5'b01110, 1'b0);
`ifdef PIPE_ADDER_SAT_EN
        send(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h8000, 5'b10101, 1'b0);
`else
        send(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 5'b01111, 1'b0);
`endif
        send(16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 5'b10010, 1'b0);
        send(16'h1111, 16'h2222, 1'b0, 1'b1, 16'h3334, 5'b00000, 1'b0);
`ifdef PIPE_ADDER_SAT_EN
        send(16'h4000, 16'hC000, 1'b1, 1'b0, 16'h7FFF, 5'b00001, 1'b0);
`else
        send(16'h4000, 16'hC000, 1'b1, 1'b0, 16'h8000, 5'b10001, 1'b0);
`endif
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (12) @(posedge clk);
    #1;
    send(16'h0101, 16'h0202, 1'b0, 1'b0, 16'h0303, 5'b00010, 1'b1);
    send(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 5'b00000, 1'b1);
    send(16'h0009, 16'h0001, 1'b1, 1'b0, 16'h0008, 5'b00100, 1'b1);
    rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    chk("midrst_out_valid", W'(out_valid), W'(0));
    chk("midrst_in_ready", W'(in_ready), W'(1));
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_idle", W'(out_valid), W'(0));
    end
    @(posedge clk);
    #1;
    send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 5'b00000, 1'b1);
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain got=%0d exp=0 pending", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
